// File: rtl/or1200_tb_mmio_host.sv
// rtl/or1200_tb_mmio_host.sv - host-services Wishbone slave: console FIFO, exit register, cycle counter
module or1200_tb_mmio_host #(
    parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    input  logic        dwb_we_i,
    input  logic [31:0] dwb_adr_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic [31:0] dwb_dat_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        dwb_err_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i,
    output logic        exit_valid_o,
    output logic [31:0] exit_code_o
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    localparam logic [7:0] OFF_CON_TX = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_EXIT   = 8'h08;
    localparam logic [7:0] OFF_CYC_LO = 8'h0C;
    localparam logic [7:0] OFF_CYC_HI = 8'h10;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  rst_sync;
    logic        rst_int_n;

    logic [7:0]  req_off;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;

    logic        hit;
    logic        reg_ok;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        resp_wr;
    logic        resp_rd;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, overflow;
    logic          push_req, push, pop;

    logic [63:0] cyc_cnt;
    logic [31:0] cyc_snap;
    logic [31:0] exit_code;
    logic        exit_valid;
    logic [31:0] status;

    // Reset asserts immediately but releases only after two clean clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync[1];

    assign hit = dwb_cyc_i & dwb_stb_i & (dwb_adr_i[31:8] == BASE_ADDR[31:8]);

    // Response state register; hits are only accepted while idle
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the accepted request so the response cycle works from stable values
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            req_off <= 8'h00;
            req_we  <= 1'b0;
            req_sel <= 4'h0;
            req_dat <= 32'h0;
        end else if (state == IDLE && hit) begin
            req_off <= dwb_adr_i[7:0];
            req_we  <= dwb_we_i;
            req_sel <= dwb_sel_i;
            req_dat <= dwb_dat_i;
        end
    end

    assign status = {16'h0, 8'(count), 5'b0, overflow, full, empty};

    // Next state plus ack/err/read-data decode for the response cycle
    always_comb begin
        state_nxt = state;
        reg_ok    = 1'b0;
        ack       = 1'b0;
        err       = 1'b0;
        rdata     = 32'h0;
        case (state)
            IDLE: begin
                if (hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                case (req_off)
                    OFF_CON_TX, OFF_STATUS, OFF_EXIT,
                    OFF_CYC_LO, OFF_CYC_HI: reg_ok = 1'b1;
                    default:                reg_ok = 1'b0;
                endcase
                ack = reg_ok;
                err = !reg_ok;
                if (reg_ok && !req_we) begin
                    case (req_off)
                        OFF_STATUS: rdata = status;
                        OFF_EXIT:   rdata = exit_code;
                        OFF_CYC_LO: rdata = cyc_cnt[31:0];
                        OFF_CYC_HI: rdata = cyc_snap;
                        default:    rdata = 32'h0;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dwb_ack_o = ack;
    assign dwb_err_o = err;
    assign dwb_dat_o = rdata;

    assign resp_wr = ack & req_we;
    assign resp_rd = ack & !req_we;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign pop      = !empty & con_ready_i;
    assign push_req = resp_wr & (req_off == OFF_CON_TX) & req_sel[0];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign push     = push_req & (!full | pop);

    // Console FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_dat[7:0];
        end
    end

    // Console FIFO pointers, fill count and sticky overflow
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end else if (resp_wr && req_off == OFF_STATUS && req_sel != 4'h0) begin
                overflow <= 1'b0;
            end
        end
    end

    assign con_valid_o = !empty;
    assign con_data_o  = empty ? 8'h00 : fifo_mem[rd_ptr];

    // Exit code keeps the first value written; later writes are acked and dropped
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            exit_valid <= 1'b0;
            exit_code  <= 32'h0;
        end else if (resp_wr && req_off == OFF_EXIT && req_sel != 4'h0 && !exit_valid) begin
            exit_valid <= 1'b1;
            exit_code  <= req_dat;
        end
    end

    assign exit_valid_o = exit_valid;
    assign exit_code_o  = exit_code;

    // Free-running cycle counter
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cyc_cnt <= 64'h0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'h1;
        end
    end

    // Reading the low word freezes the high word so a LO-then-HI pair is coherent
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cyc_snap <= 32'h0;
        end else if (resp_rd && req_off == OFF_CYC_LO) begin
            cyc_snap <= cyc_cnt[63:32];
        end
    end

endmodule

// File: tb/tb_or1200_tb_mmio_host.sv
// tb/tb_or1200_tb_mmio_host.sv - directed self-checking bench for or1200_tb_mmio_host
module tb_or1200_tb_mmio_host;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dwb_cyc_i;
    logic        dwb_stb_i;
    logic        dwb_we_i;
    logic [31:0] dwb_adr_i;
    logic [3:0]  dwb_sel_i;
    logic [31:0] dwb_dat_i;
    logic [31:0] dwb_dat_o;
    logic        dwb_ack_o;
    logic        dwb_err_o;
    logic        con_valid_o;
    logic [7:0]  con_data_o;
    logic        con_ready_i;
    logic        exit_valid_o;
    logic [31:0] exit_code_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;
    logic [31:0] lo1, hi1, lo2, hi2;
    int          seen;

    or1200_tb_mmio_host #(
        .BASE_ADDR  (32'h9000_0000),
        .FIFO_DEPTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dwb_cyc_i    (dwb_cyc_i),
        .dwb_stb_i    (dwb_stb_i),
        .dwb_we_i     (dwb_we_i),
        .dwb_adr_i    (dwb_adr_i),
        .dwb_sel_i    (dwb_sel_i),
        .dwb_dat_i    (dwb_dat_i),
        .dwb_dat_o    (dwb_dat_o),
        .dwb_ack_o    (dwb_ack_o),
        .dwb_err_o    (dwb_err_o),
        .con_valid_o  (con_valid_o),
        .con_data_o   (con_data_o),
        .con_ready_i  (con_ready_i),
        .exit_valid_o (exit_valid_o),
        .exit_code_o  (exit_code_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle request; returns sampled response from the following cycle
    task automatic wb(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                      input logic [31:0] dat);
        @(negedge clk);
        dwb_cyc_i = 1'b1;
        dwb_stb_i = 1'b1;
        dwb_we_i  = we;
        dwb_adr_i = adr;
        dwb_sel_i = sel;
        dwb_dat_i = dat;
        @(negedge clk);
        dwb_cyc_i = 1'b0;
        dwb_stb_i = 1'b0;
        r_ack = dwb_ack_o;
        r_err = dwb_err_o;
        r_dat = dwb_dat_o;
    endtask

    initial begin
        rst_n       = 1'b0;
        dwb_cyc_i   = 1'b0;
        dwb_stb_i   = 1'b0;
        dwb_we_i    = 1'b0;
        dwb_adr_i   = 32'h0;
        dwb_sel_i   = 4'h0;
        dwb_dat_i   = 32'h0;
        con_ready_i = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_ack",        64'(dwb_ack_o),    64'h0);
        check("rst_err",        64'(dwb_err_o),    64'h0);
        check("rst_dat",        64'(dwb_dat_o),    64'h0);
        check("rst_con_valid",  64'(con_valid_o),  64'h0);
        check("rst_con_data",   64'(con_data_o),   64'h0);
        check("rst_exit_valid", 64'(exit_valid_o), 64'h0);
        check("rst_exit_code",  64'(exit_code_o),  64'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        wb(32'h9000_0004, 1'b0, 4'hF, 32'h0);
        check("status_after_rst", 64'({r_ack, r_err, r_dat}), 64'({2'b10, 32'h0000_0001}));

        // console burst
        con_ready_i = 1'b1;
        wb(32'h9000_0000, 1'b1, 4'h1, 32'h0000_0048);
        check("burst_H_ack", 64'({r_ack, r_err}), 64'h2);
        @(negedge clk);
        check("burst_H_data", 64'({con_valid_o, con_data_o}), 64'h148);
        wb(32'h9000_0000, 1'b1, 4'h1, 32'h0000_0069);
        check("burst_i_ack", 64'({r_ack, r_err}), 64'h2);
        @(negedge clk);
        check("burst_i_data", 64'({con_valid_o, con_data_o}), 64'h169);
        @(negedge clk);
        check("burst_empty", 64'(con_valid_o), 64'h0);

        // overflow
        con_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wb(32'h9000_0000, 1'b1, 4'h1, 32'(8'h10 + i));
        end
        wb(32'h9000_0004, 1'b0, 4'hF, 32'h0);
        check("ovf_status", 64'(r_dat), 64'h1006);
        wb(32'h9000_0004, 1'b1, 4'h1, 32'h0);
        wb(32'h9000_0004, 1'b0, 4'hF, 32'h0);
        check("ovf_cleared", 64'(r_dat), 64'h1002);
        @(negedge clk);
        con_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain", 64'({con_valid_o, con_data_o}), 64'({1'b1, 8'(8'h10 + i)}));
            @(negedge clk);
        end
        check("ovf_drained_empty", 64'(con_valid_o), 64'h0);

        // full plus simultaneous pop
        con_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wb(32'h9000_0000, 1'b1, 4'h1, 32'(8'h40 + i));
        end
        @(negedge clk);
        dwb_cyc_i = 1'b1;
        dwb_stb_i = 1'b1;
        dwb_we_i  = 1'b1;
        dwb_adr_i = 32'h9000_0000;
        dwb_sel_i = 4'h1;
        dwb_dat_i = 32'h0000_00AA;
        @(posedge clk);
        #1;
        dwb_cyc_i   = 1'b0;
        dwb_stb_i   = 1'b0;
        con_ready_i = 1'b1;
        @(negedge clk);
        check("fullpop_ack", 64'(dwb_ack_o), 64'h1);
        @(posedge clk);
        #1;
        con_ready_i = 1'b0;
        wb(32'h9000_0004, 1'b0, 4'hF, 32'h0);
        check("fullpop_status", 64'(r_dat), 64'h1002);
        check("fullpop_head", 64'(con_data_o), 64'h41);
        @(negedge clk);
        con_ready_i = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("fullpop_drain", 64'({con_valid_o, con_data_o}), 64'({1'b1, 8'(8'h40 + i)}));
            @(negedge clk);
        end
        check("fullpop_last", 64'({con_valid_o, con_data_o}), 64'h1AA);
        @(negedge clk);
        check("fullpop_empty", 64'(con_valid_o), 64'h0);
        con_ready_i = 1'b0;

        // exit register
        wb(32'h9000_0008, 1'b1, 4'hF, 32'h0000_002A);
        wb(32'h9000_0008, 1'b1, 4'hF, 32'h0000_0007);
        check("exit_second_ack", 64'(r_ack), 64'h1);
        check("exit_valid", 64'(exit_valid_o), 64'h1);
        check("exit_code",  64'(exit_code_o),  64'h2A);
        wb(32'h9000_0008, 1'b0, 4'hF, 32'h0);
        check("exit_read", 64'({r_ack, r_dat}), 64'({1'b1, 32'h2A}));
        wb(32'h9000_0000, 1'b0, 4'hF, 32'h0);
        check("con_tx_read_zero", 64'({r_ack, r_dat}), 64'({1'b1, 32'h0}));
        wb(32'h9000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
        check("cyc_hi_write_ack", 64'({r_ack, r_err}), 64'h2);

        // decode
        wb(32'h9000_0014, 1'b0, 4'hF, 32'h0);
        check("bad_offset", 64'({r_ack, r_err, r_dat}), 64'({2'b01, 32'h0}));
        wb(32'h0000_1000, 1'b1, 4'h1, 32'h0000_0055);
        check("miss_no_resp", 64'({r_ack, r_err}), 64'h0);
        @(negedge clk);
        check("miss_no_push", 64'(con_valid_o), 64'h0);

        // cycle snapshot across the 32-bit wrap
        @(negedge clk);
        force dut.cyc_cnt = 64'h0000_0000_FFFF_FFF0;
        @(negedge clk);
        release dut.cyc_cnt;
        wb(32'h9000_000C, 1'b0, 4'hF, 32'h0);
        lo1 = r_dat;
        repeat (20) @(negedge clk);
        wb(32'h9000_0010, 1'b0, 4'hF, 32'h0);
        hi1 = r_dat;
        check("snap_lo_before_wrap", 64'(lo1[31:4]), 64'h0FFF_FFFF);
        check("snap_hi_latched",     64'(hi1),       64'h0);
        wb(32'h9000_000C, 1'b0, 4'hF, 32'h0);
        lo2 = r_dat;
        wb(32'h9000_0010, 1'b0, 4'hF, 32'h0);
        hi2 = r_dat;
        check("snap_hi_after_wrap", 64'(hi2),              64'h1);
        check("snap_lo_after_wrap", 64'(lo2 < 32'h100),    64'h1);

        // reset in the response cycle
        wb(32'h9000_0000, 1'b1, 4'h1, 32'h0000_005A);
        @(negedge clk);
        dwb_cyc_i = 1'b1;
        dwb_stb_i = 1'b1;
        dwb_we_i  = 1'b0;
        dwb_adr_i = 32'h9000_0004;
        dwb_sel_i = 4'hF;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        dwb_cyc_i = 1'b0;
        dwb_stb_i = 1'b0;
        #1;
        check("midrst_ack",        64'({dwb_ack_o, dwb_err_o}), 64'h0);
        check("midrst_dat",        64'(dwb_dat_o),    64'h0);
        check("midrst_con",        64'({con_valid_o, con_data_o}), 64'h0);
        check("midrst_exit_valid", 64'(exit_valid_o), 64'h0);
        check("midrst_exit_code",  64'(exit_code_o),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (6) begin
            @(negedge clk);
            if (dwb_ack_o || dwb_err_o) seen++;
        end
        check("midrst_no_late_ack", 64'(seen), 64'h0);
        wb(32'h9000_0010, 1'b0, 4'hF, 32'h0);
        check("snap_reset", 64'({r_ack, r_dat}), 64'({1'b1, 32'h0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/or1200_tb_mmio_host.md
# or1200_tb_mmio_host

Memory-mapped host-services slave for the OR1200 simulation bench. It sits on the data Wishbone bus next to the data-memory model. It decodes a small register window and provides:
- a buffered console byte stream with a valid/ready drain port,
- a sticky program-exit register that the C++ harness polls,
- a free-running 64-bit cycle counter with a coherent snapshot read.

Accesses outside its window are ignored, so the data-memory model and this block share the bus without arbitration.

## Interface
Parameters:
- BASE_ADDR, 32'h9000_0000: window base; the window is 256 bytes, and BASE_ADDR[7:0] must be 0.
- FIFO_DEPTH, 16: console FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  in  1  bench clock.
- rst_n  in  1  asynchronous active-low reset.
- dwb_cyc_i  in  1  Wishbone cycle.
- dwb_stb_i  in  1  Wishbone strobe.
- dwb_we_i  in  1  write enable.
- dwb_adr_i  in  32  byte address.
- dwb_sel_i  in  4  byte lanes.
- dwb_dat_i  in  32  write data from the CPU.
- dwb_dat_o  out  32  read data; 0 when not acking.
- dwb_ack_o  out  1  one-cycle acknowledge.
- dwb_err_o  out  1  one-cycle error; asserted instead of ack.
- con_valid_o  out  1  console byte available.
- con_data_o  out  8  FIFO head byte.
- con_ready_i  in  1  consumer accepts the byte.
- exit_valid_o  out  1  sticky; program has written EXIT.
- exit_code_o  out  32  first value written to EXIT.

## Operation
- **Hit:** dwb_cyc_i & dwb_stb_i & (dwb_adr_i[31:8] == BASE_ADDR[31:8]). Misses produce no response and no side effects.
- **Register map (offset = dwb_adr_i[7:0]):**
  - 0x00 CON_TX, W: if dwb_sel_i[0], push dwb_dat_i[7:0]. Reads return 0.
  - 0x04 STATUS, R: bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] fill count. Any write with sel != 0 clears overflow.
  - 0x08 EXIT, W: on the first write with sel != 0, capture dwb_dat_i (all 32 bits) and set exit_valid_o. Later writes are acked and ignored. Reads return exit_code_o.
  - 0x0C CYC_LO, R: returns counter[31:0] and latches counter[63:32] into the snapshot register.
  - 0x10 CYC_HI, R: returns the snapshot register, not the live counter.
  - Writes to 0x0C and 0x10 are acked and ignored.
  - Any other offset: err instead of ack, no side effects.
- **Side effects:** all register side effects occur in the response cycle, which is the cycle in which ack is driven.
- **Console FIFO:**
  - con_valid_o = !empty; con_data_o = head entry.
  - Pop when con_valid_o & con_ready_i.
  - Push when not full, or when a pop occurs in the same cycle. A push in that case succeeds and the count is unchanged.
  - Push while full without a pop: byte dropped, overflow set.
  - Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- **Cycle counter:** 64-bit, increments every cycle after reset, wraps to 0.
- **Response FSM:**
  - States IDLE and RESP.
  - IDLE → RESP on a hit; the hit is registered (addr, we, sel, data).
  - RESP drives ack or err for exactly one cycle, then → IDLE unconditionally.
  - A hit sampled while in RESP is not accepted. The strobe must still be asserted in the following IDLE cycle to be taken.

## Timing
- Request in cycle N gives ack/err in cycle N+1. A held strobe therefore gets a response every 2 cycles.
- dwb_dat_o is valid only in the ack cycle and is 0 otherwise.
- FIFO push is visible on con_valid_o in the cycle after the ack cycle.
- **Reset (async assert, sync-safe release):** all outputs 0, FIFO empty, overflow 0, counter 0, snapshot 0, FSM IDLE.
- **Reset mid-transaction:** the pending response is discarded and no ack is issued after release.
- **STATUS read together with a pop:** returns the count registered before the pop.

## Test plan
- **Console burst:** write 'H','i' to 0x9000_0000 with sel=0001 and con_ready_i=1 → ack one cycle after each request; con_data_o shows 0x48 then 0x69; FIFO empty afterwards.
- **Overflow:** con_ready_i=0, write 17 bytes (FIFO_DEPTH=16) → STATUS reads 0x1006 (count 16, full, overflow). Write STATUS → overflow clears. Raise ready → exactly 16 bytes drain in order.
- **Full plus simultaneous pop:** FIFO full, con_ready_i=1 during the push ack cycle → byte accepted, count stays 16, overflow stays 0.
- **Exit:** write 0x0000_002A then 0x0000_0007 to 0x08 → exit_valid_o=1, exit_code_o=0x2A. Read 0x08 → 0x2A.
- **Cycle snapshot:** force the counter near 0x0000_0000_FFFF_FFFF; read LO then HI across the wrap → HI equals the value latched at the LO read, and LO:HI is consistent.
- **Decode and reset:**
  - Access offset 0x14 → dwb_err_o pulse, no ack.
  - Access 0x0000_1000 → no response.
  - Assert rst_n low during the RESP state → no ack; all outputs 0.
